// File: rtl/sipo_frame_if.sv
// Serial-in / frame-out handshake bundle for sipo_frame.
// The master drives serial data and flow control; the slave returns the frame and status.
interface sipo_frame_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             din;
  logic             load;
  logic             clr;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output din, load, clr, dout_ready,
    input  dout, dout_valid, overrun, bit_cnt
  );

  modport slave (
    input  din, load, clr, dout_ready,
    output dout, dout_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_frame.sv
// Serial-to-parallel frame assembler with a one-deep valid/ready output register
// and a sticky overrun flag for frames dropped while the output is still pending.
module sipo_frame #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  sipo_frame_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] asm_reg;
  logic [WIDTH-1:0] frame_next;
  logic [WIDTH-1:0] dout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic             capture;
  logic             complete;
  logic             accept;

  // Each bit position is written only when the counter points at it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    localparam int POS = MSB_FIRST ? (WIDTH - 1 - gi) : gi;
    assign frame_next[gi] = (cnt_reg == CW'(POS)) ? bus.din : asm_reg[gi];
  end

  assign capture  = bus.load && !bus.clr;
  assign complete = capture && (cnt_reg == LAST);
  assign accept   = valid_reg && bus.dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg     <= '0;
      cnt_reg     <= '0;
      dout_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (bus.clr) begin
        asm_reg     <= '0;
        cnt_reg     <= '0;
        overrun_reg <= 1'b0;
      end else if (bus.load) begin
        if (complete) begin
          asm_reg <= '0;
          cnt_reg <= '0;
        end else begin
          asm_reg <= frame_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      // A completing frame may replace a pending one only if it is accepted this edge.
      if (complete) begin
        if (!valid_reg || bus.dout_ready) begin
          dout_reg  <= frame_next;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (accept) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = valid_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.bit_cnt    = cnt_reg;
endmodule

// File: tb/tb_sipo_frame.sv
// Directed vector bench for sipo_frame: LSB-first and MSB-first instances share one stimulus.
module tb_sipo_frame;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic load = 1'b0;
  logic clr = 1'b0;
  logic rdy = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sipo_frame_if #(.WIDTH(8)) bus0 ();
  sipo_frame_if #(.WIDTH(8)) bus1 ();

  assign bus0.din = din;
  assign bus0.load = load;
  assign bus0.clr = clr;
  assign bus0.dout_ready = rdy;
  assign bus1.din = din;
  assign bus1.load = load;
  assign bus1.clr = clr;
  assign bus1.dout_ready = rdy;

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic       din;
    logic       load;
    logic       clr;
    logic       rdy;
    int         cnt;
    logic       vld;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic v(input logic din_i, input logic load_i, input logic clr_i, input logic rdy_i,
                   input int cnt_i, input logic vld_i, input logic [7:0] d0_i,
                   input logic [7:0] d1_i, input logic ovr_i);
    vec_t e;
    e.din = din_i; e.load = load_i; e.clr = clr_i; e.rdy = rdy_i;
    e.cnt = cnt_i; e.vld = vld_i; e.d0 = d0_i; e.d1 = d1_i; e.ovr = ovr_i;
    vecs.push_back(e);
  endtask

  // First seven bits of a frame (LSB of s sent first); expectations are constant across them.
  task automatic bits7(input logic [7:0] s, input logic rdy_i, input logic vld_i,
                       input logic [7:0] d0_i, input logic [7:0] d1_i, input logic ovr_i);
    for (int i = 0; i < 7; i++)
      v(s[i], 1'b1, 1'b0, rdy_i, i + 1, vld_i, d0_i, d1_i, ovr_i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic vld,
                         input logic [7:0] d0, input logic [7:0] d1, input logic ovr);
    chk({tag, " cnt0"}, 64'(bus0.bit_cnt), 64'(cnt));
    chk({tag, " cnt1"}, 64'(bus1.bit_cnt), 64'(cnt));
    chk({tag, " vld0"}, 64'(bus0.dout_valid), 64'(vld));
    chk({tag, " vld1"}, 64'(bus1.dout_valid), 64'(vld));
    chk({tag, " dout0"}, 64'(bus0.dout), 64'(d0));
    chk({tag, " dout1"}, 64'(bus1.dout), 64'(d1));
    chk({tag, " ovr0"}, 64'(bus0.overrun), 64'(ovr));
    chk({tag, " ovr1"}, 64'(bus1.overrun), 64'(ovr));
  endtask

  localparam logic [7:0] S = 8'h4D;  // stream 1,0,1,1,0,0,1,0
  localparam logic [7:0] A = 8'hA5;  // stream 1,0,1,0,0,1,0,1

  initial begin
    // Frame with output held off: 4D LSB-first, B2 MSB-first.
    bits7(S, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    // All-ones frame dropped while 4D is pending.
    bits7(8'hFF, 1'b0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h4D, 8'hB2, 1'b1);
    // Partial frame aborted by clr; load/din ignored on that edge.
    v(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h4D, 8'hB2, 1'b1);
    v(1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h4D, 8'hB2, 1'b1);
    v(1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 8'h4D, 8'hB2, 1'b1);
    v(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h4D, 8'hB2, 1'b0);
    // Load gap of three cycles after the fourth bit; din toggled during the gap.
    v(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    // Always-ready consumer, 16 back-to-back bits: one valid cycle per frame.
    bits7(S, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    bits7(A, 1'b1, 1'b0, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 8'hA5, 8'hA5, 1'b0);
    v(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 8'hA5, 1'b0);
    // Completion on the same edge that accepts the pending frame.
    bits7(S, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0);
    v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    bits7(A, 1'b0, 1'b1, 8'h4D, 8'hB2, 1'b0);
    v(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 8'hA5, 8'hA5, 1'b0);
    v(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 8'hA5, 1'b0);

    // Reset state, sampled after a clock edge while rst_n is still low.
    #12;
    chk_all("reset", 0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      din = vecs[i].din; load = vecs[i].load; clr = vecs[i].clr; rdy = vecs[i].rdy;
      step();
      $display("vec %0d: din=%0b load=%0b clr=%0b rdy=%0b -> cnt=%0d vld=%0b d0=%h d1=%h ovr=%0b",
               i, din, load, clr, rdy, bus0.bit_cnt, bus0.dout_valid, bus0.dout, bus1.dout,
               bus0.overrun);
      chk_all($sformatf("v%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].ovr);
    end

    // Mid-cycle reset after five captured bits, with a frame pending and overrun set.
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin din = S[i]; load = 1'b1; step(); end
    for (int i = 0; i < 8; i++) begin din = 1'b1; load = 1'b1; step(); end
    for (int i = 0; i < 5; i++) begin din = S[i]; load = 1'b1; step(); end
    chk_all("pre_rst", 5, 1'b1, 8'h4D, 8'hB2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 8'h00, 8'h00, 1'b0);
    $display("async reset: cnt=%0d vld=%0b d0=%h ovr=%0b",
             bus0.bit_cnt, bus0.dout_valid, bus0.dout, bus0.overrun);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin din = S[i]; load = 1'b1; step(); end
    chk({"post_rst7 vld0"}, 64'(bus0.dout_valid), 64'(0));
    chk({"post_rst7 cnt0"}, 64'(bus0.bit_cnt), 64'(7));
    din = S[7]; step();
    load = 1'b0;
    $display("post reset frame: d0=%h d1=%h vld=%0b", bus0.dout, bus1.dout, bus0.dout_valid);
    chk_all("post_rst", 0, 1'b1, 8'h4D, 8'hB2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sipo_frame.md
SIPO_FRAME -- requirements
Module: sipo_frame

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning frame length in bits; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning 0 = first sampled bit lands in dout[0] and 1 = first sampled bit lands in dout[WIDTH-1].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, 1 bit: serial data, sampled only when load=1.
REQ-006 SHALL have port load, input, 1 bit: shift enable, one bit captured per clk edge while high.
REQ-007 SHALL have port clr, input, 1 bit: synchronous abort of the partial frame.
REQ-008 SHALL have port dout_ready, input, 1 bit: consumer accepts dout.
REQ-009 SHALL have port dout, output, WIDTH bits: last completed frame, registered.
REQ-010 SHALL have port dout_valid, output, 1 bit: dout holds an unaccepted frame.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, a completed frame was dropped.
REQ-012 SHALL have port bit_cnt, output, $clog2(WIDTH) bits: bits captured into the current partial frame.

Function
REQ-013 SHALL, on an edge with load=1 and clr=0, write din into the assembly register at index bit_cnt (MSB_FIRST=0) or WIDTH-1-bit_cnt (MSB_FIRST=1), and increment bit_cnt.
REQ-014 SHALL hold the assembly register and bit_cnt unchanged on edges with load=0; gaps in load SHALL NOT corrupt the frame.
REQ-015 SHALL treat an edge with load=1 and bit_cnt=WIDTH-1 as frame completion: the assembled frame, including the bit sampled on that edge, becomes the completed frame; bit_cnt wraps to 0; assembly register clears to 0.
REQ-016 SHALL, on completion when dout_valid=0, or dout_valid=1 with dout_ready=1 on the same edge, load dout with the completed frame and set dout_valid=1 (visible the cycle after the last bit).
REQ-017 SHALL, on completion when dout_valid=1 and dout_ready=0, drop the completed frame, keep dout unchanged, and set overrun=1.
REQ-018 SHALL clear dout_valid on an edge with dout_valid=1, dout_ready=1 and no simultaneous completion.
REQ-019 SHALL keep dout stable while dout_valid=1; dout_ready with dout_valid=0 SHALL have no effect.
REQ-020 SHALL, on an edge with clr=1, set bit_cnt=0, clear the assembly register and clear overrun, ignoring load/din that edge; dout and dout_valid SHALL be unaffected, and the handshake of REQ-018 SHALL still apply.
REQ-021 SHALL keep overrun set until clr or reset; further drops SHALL leave it at 1.
REQ-022 SHALL expose bit_cnt directly from the counter register (0..WIDTH-1).

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force dout=0, dout_valid=0, overrun=0, bit_cnt=0 and assembly register=0, independent of clk.
REQ-024 SHALL resume capturing on the first clk edge after rst_n rises; a partial frame in progress at reset SHALL be discarded.

Verification
REQ-025 SHALL cover: WIDTH=8, MSB_FIRST=0, load=1 for 8 edges, din=1,0,1,1,0,0,1,0, dout_ready=0 -> dout=8'h4D, dout_valid=1 the cycle after the 8th edge, bit_cnt=0.
REQ-026 SHALL cover: the same stream with MSB_FIRST=1 and load deasserted for 3 cycles after the 4th bit -> dout=8'hB2, dout_valid asserted only after the 8th captured bit.
REQ-027 SHALL cover: dout_ready=0, frame 8'h4D then 8 bits of 1 -> dout stays 8'h4D, overrun=1; a clr pulse -> overrun=0 and dout_valid stays 1.
REQ-028 SHALL cover: dout_ready=1 permanently, 16 continuous bits forming 8'h4D then 8'hA5 -> dout_valid high for exactly one cycle per frame, no overrun.
REQ-029 SHALL cover: completion on the same edge as accept of the pending frame -> dout switches to the new frame and dout_valid stays 1 without a gap.
REQ-030 SHALL cover: rst_n pulsed low mid-cycle after 5 captured bits -> all outputs 0 immediately; the next 8 bits 1,0,1,1,0,0,1,0 give dout=8'h4D.
